// File: rtl/clk_monitor.sv
// Slow-clock monitor: synchronizes sig_in, measures period/high time in clock_in cycles.
// Optional duty measurement enabled by defining CLK_MON_DUTY_EN.
module clk_monitor #(
    parameter int unsigned      CNT_W       = 28,
    parameter logic [CNT_W-1:0] TIMEOUT     = 28'd1000,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             ack,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             rise_pulse,
    output logic             lost,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_LOST
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - CNT_W'(1);

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic             s_prev_q, s_prev_d;
    logic             s_sync;
    logic             rise;
    logic             capture;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             lost_q, lost_d;
    logic             overrun_q, overrun_d;

    assign s_sync = sync_q[SYNC_STAGES-1];
    assign rise   = s_sync & ~s_prev_q;

    always_ff @(posedge clock_in) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (rise) state_d = S_MEASURE;
            S_MEASURE: if (!rise && cnt_q == CNT_LAST) state_d = S_LOST;
            S_LOST:    if (rise) state_d = S_MEASURE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_prev_d = s_sync;
        capture  = rise && (state_q == S_MEASURE);

        // Saturate at the last legal count; the FSM leaves MEASURE there
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        period_d = capture ? cnt_q + CNT_W'(1) : period_q;

        valid_d = valid_q;
        if (capture) begin
            valid_d = 1'b1;
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end

        overrun_d = overrun_q | (capture & valid_q);

        lost_d = lost_q;
        if (state_q == S_MEASURE && !rise && cnt_q == CNT_LAST) begin
            lost_d = 1'b1;
        end else if (state_q == S_LOST && rise) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clock_in) begin
        if (rst) begin
            sync_q    <= '0;
            s_prev_q  <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            s_prev_q  <= s_prev_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            overrun_q <= overrun_d;
        end
    end

`ifdef CLK_MON_DUTY_EN
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] high_q, high_d;

    // The rise cycle itself is high, so a new period starts at one
    always_comb begin
        hcnt_d = hcnt_q;
        if (rise) begin
            hcnt_d = CNT_W'(1);
        end else if (s_sync && hcnt_q != TIMEOUT) begin
            hcnt_d = hcnt_q + CNT_W'(1);
        end
        high_d = capture ? hcnt_q : high_q;
    end

    always_ff @(posedge clock_in) begin
        if (rst) begin
            hcnt_q <= '0;
            high_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            high_q <= high_d;
        end
    end

    assign high_out = high_q;
`else
    assign high_out = '0;
`endif

    assign period_out = period_q;
    assign valid      = valid_q;
    assign lost       = lost_q;
    assign overrun    = overrun_q;
    assign rise_pulse = rise & ~rst;

endmodule
